// File: rtl/routing_pkg.sv
// Shared constants and index helpers for the lane routing network.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package routing_pkg;

   // Stage select value that passes lanes straight through
   localparam int SB_PASS = 0;

   // Stage select value that selects full bit reversal for a given log2 size
   function automatic int bitrev_code(input int log2n);
      return log2n;
   endfunction

   // Width of the stage select field: enough bits to encode 0..log2n
   function automatic int sbw(input int log2n);
      return $clog2(log2n + 1);
   endfunction

   // Reverse the low nbits of idx
   function automatic int bitrev(input int idx, input int nbits);
      int r;
      r = 0;
      for (int b = 0; b < nbits; b++) begin
         r = r | (((idx >> b) & 1) << (nbits - 1 - b));
      end
      return r;
   endfunction

endpackage

// File: rtl/routing_perm.sv
// Combinational lane permutation for one sample plane (real or imaginary).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the instantiating block owns flow control.
module routing_perm
   import routing_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LOG2N = 5
) (
   input  logic [WIDTH*(2**LOG2N)-1:0] in_lanes,
   input  logic [sbw(LOG2N)-1:0]       sb,
   input  logic                        inv,
   output logic [WIDTH*(2**LOG2N)-1:0] out_lanes
);

   localparam int N = 2**LOG2N;

   // Per output lane, pick the source lane for the selected stage; illegal stages give zeros
   always_comb begin
      int s;
      int h;
      int g;
      int r;
      int src;
      out_lanes = '0;
      s = int'(sb);
      for (int k = 0; k < N; k++) begin
         h   = 1;
         g   = 0;
         r   = 0;
         src = k;
         if (s == SB_PASS) begin
            src = k;
         end else if (s == bitrev_code(LOG2N)) begin
            src = bitrev(k, LOG2N);
         end else if (s < LOG2N) begin
            // Group of 2h lanes; r is the offset of lane k within its group
            h = 1 << s;
            g = k & ~(2 * h - 1);
            r = k - g;
            if (!inv) begin
               // Even lanes to the lower half, odd lanes to the upper half
               src = (r < h) ? (g + 2 * r) : (g + 2 * (r - h) + 1);
            end else begin
               // Re-interleave the two halves
               src = ((r % 2) == 1) ? (g + h + r / 2) : (g + r / 2);
            end
         end
         if (s <= LOG2N) begin
            out_lanes[k*WIDTH +: WIDTH] = in_lanes[src*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/routing_network_pipelined.sv
// Pipelined lane routing network: permutes a complex frame by stage select.
// Latency: 1 cycle from input acceptance to output valid.
// Backpressure: single output register; in_ready = !out_valid || out_ready, full throughput.
module routing_network_pipelined
   import routing_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LOG2N = 5
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH*(2**LOG2N)-1:0] in_real,
   input  logic [WIDTH*(2**LOG2N)-1:0] in_imag,
   input  logic [sbw(LOG2N)-1:0]       in_sb,
   input  logic                        in_inv,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH*(2**LOG2N)-1:0] out_real,
   output logic [WIDTH*(2**LOG2N)-1:0] out_imag,
   output logic [sbw(LOG2N)-1:0]       out_sb,
   output logic                        err_sb,
   output logic [15:0]                 frame_cnt
);

   localparam int N = 2**LOG2N;

   logic [WIDTH*N-1:0] perm_real;
   logic [WIDTH*N-1:0] perm_imag;
   logic               accept;
   logic               sb_illegal;

   routing_perm #(.WIDTH(WIDTH), .LOG2N(LOG2N)) u_perm_real (
      .in_lanes  (in_real),
      .sb        (in_sb),
      .inv       (in_inv),
      .out_lanes (perm_real)
   );

   routing_perm #(.WIDTH(WIDTH), .LOG2N(LOG2N)) u_perm_imag (
      .in_lanes  (in_imag),
      .sb        (in_sb),
      .inv       (in_inv),
      .out_lanes (perm_imag)
   );

   // Ready whenever the output slot is free or draining; forced high during reset but nothing is taken
   always_comb begin
      in_ready   = RST || !out_valid || out_ready;
      accept     = in_valid && in_ready && !RST;
      sb_illegal = int'(in_sb) > LOG2N;
   end

   // Output register: load on input transfer, empty on output-only transfer, hold otherwise
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
         out_sb    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_real  <= perm_real;
         out_imag  <= perm_imag;
         out_sb    <= in_sb;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky illegal-stage flag and wrapping accepted-frame counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_sb    <= 1'b0;
         frame_cnt <= '0;
      end else if (accept) begin
         frame_cnt <= frame_cnt + 16'd1;
         if (sb_illegal) begin
            err_sb <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_routing_network_pipelined.sv
// Directed bench for routing_network_pipelined at N=32, WIDTH=16.
// Latency: expects output one cycle after acceptance.
// Backpressure: exercises held out_ready low and simultaneous drain/reload.
module tb_routing_network_pipelined;

   localparam int WIDTH = 16;
   localparam int LOG2N = 5;
   localparam int N     = 32;
   localparam int SBW   = 3;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH*N-1:0] in_real;
   logic [WIDTH*N-1:0] in_imag;
   logic [SBW-1:0]   in_sb;
   logic             in_inv;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH*N-1:0] out_real;
   logic [WIDTH*N-1:0] out_imag;
   logic [SBW-1:0]   out_sb;
   logic             err_sb;
   logic [15:0]      frame_cnt;

   int nvec;
   int nerr;

   logic [WIDTH*N-1:0] base_real;
   logic [WIDTH*N-1:0] base_imag;
   logic [WIDTH*N-1:0] save_real;
   logic [WIDTH*N-1:0] save_imag;

   routing_network_pipelined #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
      .CLK       (clk),
      .RST       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .in_sb     (in_sb),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .out_sb    (out_sb),
      .err_sb    (err_sb),
      .frame_cnt (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lane(input logic [WIDTH*N-1:0] v, input int k);
      return v[k*WIDTH +: WIDTH];
   endfunction

   // Advance one clock and settle just past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      for (int k = 0; k < N; k++) begin
         base_real[k*WIDTH +: WIDTH] = 16'(k);
         base_imag[k*WIDTH +: WIDTH] = 16'(100 + k);
      end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_real = base_real; in_imag = base_imag; in_sb = '0; in_inv = 1'b0;
      step(); step();
      chk("rst_out_valid", 512'(out_valid), 512'd0);
      chk("rst_err_sb",    512'(err_sb),    512'd0);
      chk("rst_frame_cnt", 512'(frame_cnt), 512'd0);
      chk("rst_out_real",  512'(out_real),  512'd0);
      chk("rst_in_ready",  512'(in_ready),  512'd1);
      rst = 1'b0;
      step();

      // sb=1 de-interleave
      in_valid = 1'b1; in_sb = 3'd1; in_inv = 1'b0;
      #1 chk("sb1_in_ready", 512'(in_ready), 512'd1);
      chk("sb1_pre_valid", 512'(out_valid), 512'd0);
      step();
      in_valid = 1'b0;
      chk("sb1_out_valid", 512'(out_valid), 512'd1);
      chk("sb1_r0", 512'(lane(out_real, 0)), 512'd0);
      chk("sb1_r1", 512'(lane(out_real, 1)), 512'd2);
      chk("sb1_r2", 512'(lane(out_real, 2)), 512'd1);
      chk("sb1_r3", 512'(lane(out_real, 3)), 512'd3);
      chk("sb1_i0", 512'(lane(out_imag, 0)), 512'd100);
      chk("sb1_i1", 512'(lane(out_imag, 1)), 512'd102);
      chk("sb1_i2", 512'(lane(out_imag, 2)), 512'd101);
      chk("sb1_i3", 512'(lane(out_imag, 3)), 512'd103);
      chk("sb1_out_sb", 512'(out_sb), 512'd1);
      chk("sb1_frame_cnt", 512'(frame_cnt), 512'd1);
      step();
      chk("sb1_drained", 512'(out_valid), 512'd0);

      // sb=4 forward then inverse round trip
      in_valid = 1'b1; in_sb = 3'd4; in_inv = 1'b0;
      step();
      chk("sb4_r0",  512'(lane(out_real, 0)),  512'd0);
      chk("sb4_r1",  512'(lane(out_real, 1)),  512'd2);
      chk("sb4_r16", 512'(lane(out_real, 16)), 512'd1);
      chk("sb4_i16", 512'(lane(out_imag, 16)), 512'd101);
      save_real = out_real; save_imag = out_imag;
      in_real = save_real; in_imag = save_imag; in_inv = 1'b1;
      step();
      in_valid = 1'b0;
      chk("sb4_inv_valid", 512'(out_valid), 512'd1);
      chk("sb4_inv_real", 512'(out_real), 512'(base_real));
      chk("sb4_inv_imag", 512'(out_imag), 512'(base_imag));
      step();

      // sb=5 bit reversal, inv ignored
      in_real = base_real; in_imag = base_imag;
      in_valid = 1'b1; in_sb = 3'd5; in_inv = 1'b0;
      step();
      chk("sb5_r1",  512'(lane(out_real, 1)),  512'd16);
      chk("sb5_r3",  512'(lane(out_real, 3)),  512'd24);
      chk("sb5_r31", 512'(lane(out_real, 31)), 512'd31);
      chk("sb5_i3",  512'(lane(out_imag, 3)),  512'd124);
      save_real = out_real; save_imag = out_imag;
      in_inv = 1'b1;
      step();
      in_valid = 1'b0;
      chk("sb5_inv_real", 512'(out_real), 512'(save_real));
      chk("sb5_inv_imag", 512'(out_imag), 512'(save_imag));
      step();

      // Backpressure: restart counter, stall three cycles, then drain and reload together
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 1'b0; in_valid = 1'b1; in_sb = 3'd0; in_inv = 1'b1;
      step();
      chk("bp_a_valid", 512'(out_valid), 512'd1);
      in_sb = 3'd1; in_inv = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_in_ready", 512'(in_ready), 512'd0);
         chk("bp_hold_real", 512'(out_real), 512'(base_real));
         chk("bp_hold_sb", 512'(out_sb), 512'd0);
         chk("bp_hold_valid", 512'(out_valid), 512'd1);
         step();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 512'(in_ready), 512'd1);
      step();
      in_valid = 1'b0;
      chk("bp_b_valid", 512'(out_valid), 512'd1);
      chk("bp_b_r1", 512'(lane(out_real, 1)), 512'd2);
      chk("bp_b_sb", 512'(out_sb), 512'd1);
      chk("bp_frame_cnt", 512'(frame_cnt), 512'd2);
      step();
      chk("bp_drained", 512'(out_valid), 512'd0);

      // Illegal stage, then a legal frame with the flag held
      in_valid = 1'b1; in_sb = 3'd6; in_inv = 1'b0;
      step();
      chk("sb6_valid", 512'(out_valid), 512'd1);
      chk("sb6_real", 512'(out_real), 512'd0);
      chk("sb6_imag", 512'(out_imag), 512'd0);
      chk("sb6_err", 512'(err_sb), 512'd1);
      in_sb = 3'd1;
      step();
      in_valid = 1'b0;
      chk("sb6_next_r1", 512'(lane(out_real, 1)), 512'd2);
      chk("sb6_next_i2", 512'(lane(out_imag, 2)), 512'd101);
      chk("sb6_err_sticky", 512'(err_sb), 512'd1);
      chk("sb6_frame_cnt", 512'(frame_cnt), 512'd4);
      step();

      // Reset while a frame is stalled in the output register
      out_ready = 1'b0; in_valid = 1'b1; in_sb = 3'd2;
      step();
      chk("rst_mid_valid", 512'(out_valid), 512'd1);
      rst = 1'b1;
      step();
      chk("rst_mid_out_valid", 512'(out_valid), 512'd0);
      chk("rst_mid_err", 512'(err_sb), 512'd0);
      chk("rst_mid_cnt", 512'(frame_cnt), 512'd0);
      chk("rst_mid_in_ready", 512'(in_ready), 512'd1);
      step();
      chk("rst_hold_cnt", 512'(frame_cnt), 512'd0);
      chk("rst_hold_valid", 512'(out_valid), 512'd0);
      in_valid = 1'b0; rst = 1'b0;
      step();
      chk("rst_after_valid", 512'(out_valid), 512'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/routing_network_pipelined.md
ROUTING_NETWORK_PIPELINED -- requirements
Module: routing_network_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bits per real or imaginary sample.
REQ-002 SHALL have parameter LOG2N, default 5, meaning log2 of point count N (N = 2^LOG2N, LOG2N >= 2).
REQ-003 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input frame valid.
REQ-006 SHALL have port in_ready  output  1  block accepts frame this cycle.
REQ-007 SHALL have port in_real  input  WIDTH*N  real lanes; lane k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_imag  input  WIDTH*N  imaginary lanes, same packing.
REQ-009 SHALL have port in_sb  input  SBW = clog2(LOG2N+1)  stage select.
REQ-010 SHALL have port in_inv  input  1  0 = de-interleave, 1 = inverse (interleave).
REQ-011 SHALL have port out_valid  output  1  output frame valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts frame.
REQ-013 SHALL have port out_real  output  WIDTH*N  permuted real lanes.
REQ-014 SHALL have port out_imag  output  WIDTH*N  permuted imaginary lanes.
REQ-015 SHALL have port out_sb  output  SBW  in_sb captured with the frame.
REQ-016 SHALL have port err_sb  output  1  sticky illegal-stage flag.
REQ-017 SHALL have port frame_cnt  output  16  count of accepted frames.

Function
REQ-018 SHALL define handshake: input transfer when in_valid and in_ready; output transfer when out_valid and out_ready.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, full throughput).
REQ-020 SHALL present a permuted frame on out_* the cycle after acceptance (latency 1).
REQ-021 SHALL hold out_* and out_valid stable while out_valid and !out_ready.
REQ-022 SHALL clear out_valid after output transfer with no simultaneous input transfer; simultaneous input and output transfer SHALL reload the register and keep out_valid high.
REQ-023 SHALL, for sb = 0, pass lanes straight through, regardless of in_inv.
REQ-024 SHALL, for 1 <= sb <= LOG2N-1 and in_inv = 0, use groups of G = 2^(sb+1) lanes with H = G/2: out[g+j] = in[g+2j], out[g+H+j] = in[g+2j+1], j = 0..H-1.
REQ-025 SHALL, for the same sb and in_inv = 1, apply the exact inverse: out[g+2j] = in[g+j], out[g+2j+1] = in[g+H+j].
REQ-026 SHALL, for sb = LOG2N, apply full bit-reversal, out[k] = in[bitrev_LOG2N(k)], ignoring in_inv.
REQ-027 SHALL, for sb > LOG2N, accept the frame, output all-zero lanes, and set err_sb.
REQ-028 SHALL apply identical permutation to real and imaginary lanes; lane values SHALL NOT be modified.
REQ-029 SHALL keep err_sb set until reset once set.
REQ-030 SHALL increment frame_cnt by 1 per input transfer, wrapping 0xFFFF -> 0.

Reset
REQ-031 SHALL, on RST high at a clock edge, clear out_valid, out_real, out_imag, out_sb, err_sb and frame_cnt to 0.
REQ-032 SHALL drop any frame held mid-operation on reset; no partial frame SHALL emerge afterward.
REQ-033 SHALL hold in_ready at 1 while RST is high, but SHALL NOT accept frames during reset.

Structure
REQ-034 SHALL place in shared package routing_pkg: SB_PASS = 0, bit-reverse code rule (LOG2N), SBW function, and bit-reverse index function.
REQ-035 SHALL implement the combinational permutation as sub-module routing_perm (one instance per real/imag plane); routing_network_pipelined owns handshake, registers, counters.

Verification (N=32, WIDTH=16, in lane k = k, imag lane k = 100+k)
REQ-036 SHALL test sb=1, inv=0: out_real lanes 0..3 = 0,2,1,3, out_imag lanes 0..3 = 100,102,101,103, out_valid one cycle after acceptance.
REQ-037 SHALL test sb=4, inv=0 then its output fed back with inv=1: first out lanes 0,1,16 = 0,2,1; second output equals original.
REQ-038 SHALL test sb=5: out lane 1 = 16, lane 3 = 24, lane 31 = 31; frames with inv=0 and inv=1 identical.
REQ-039 SHALL test backpressure with out_ready=0 for 3 cycles and in_valid held: in_ready=0, out_* stable; when out_ready=1, back-to-back frames with no bubble; frame_cnt = 2.
REQ-040 SHALL test sb=6: all-zero output, err_sb=1; a later legal frame outputs correctly and err_sb stays 1.
REQ-041 SHALL test RST asserted while out_valid=1 and out_ready=0: next cycle out_valid=0, err_sb=0, frame_cnt=0.
